// File: rtl/rv32i_pkg.sv
// Shared branch-unit types: funct3 encodings, BHT counter states, BTB entry.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rv32i_pkg;

  // Conditional-branch funct3 encodings (010/011 are unused by RV32I).
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Widest tag the BTB can ever need (index width 0). Narrower tags are
  // zero-extended into this field, so the unused upper bits stay constant.
  localparam int BTB_TAG_W = 30;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

  // Saturating two-bit counter step: up on taken, down on not-taken.
  function automatic bht_state_e bht_next(input bht_state_e cur, input logic taken);
    bht_state_e nxt;
    nxt = cur;
    case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/br_decide.sv
// Branch outcome decode: funct3 plus comparator flags -> {legal, taken}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
//
// Ports:
//   funct3  branch funct3 field
//   eq, lt  comparator flags (lt signedness already resolved upstream)
//   legal   funct3 is one of the six RV32I conditional branches
//   taken   branch outcome; forced 0 for illegal funct3
module br_decide
  import rv32i_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       eq,
  input  logic       lt,
  output logic       legal,
  output logic       taken
);

  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    case (funct3)
      F3_BEQ:           taken = eq;
      F3_BNE:           taken = ~eq;
      F3_BLT, F3_BLTU:  taken = lt;
      F3_BGE, F3_BGEU:  taken = ~lt;
      default: begin
        legal = 1'b0;
        taken = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/br_predictor.sv
// Branch resolution and prediction: direct-mapped BHT/BTB read by IF, trained by EX.
// Latency: prediction and mispredict/redirect are combinational; table and counter updates land on the next i_clk edge.
// Backpressure: none; one prediction and at most one update accepted every cycle.
//
// Ports:
//   i_clk, i_rst_n         clock (rising edge), asynchronous active-low reset
//   i_pc_f                 IF PC -> o_pred_taken / o_pred_target
//   i_upd_*, i_br_eq/lt    EX branch being resolved this cycle
//   o_mispredict           flush request, with o_redirect_pc as the correct next PC
//   o_br_cnt, o_mis_cnt    saturating resolved-branch and mispredict counters
module br_predictor
  import rv32i_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc_f,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic [2:0]  i_upd_funct3,
  input  logic        i_br_eq,
  input  logic        i_br_lt,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_pred_taken,
  input  logic [31:0] i_upd_pred_target,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mis_cnt
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  btb_entry_t btb [DEPTH];
  bht_state_e bht [DEPTH];

  // Tag is everything above the index; zero-extended into the entry field.
  function automatic logic [BTB_TAG_W-1:0] pc_tag(input logic [31:0] pc);
    logic [TAG_W-1:0] t;
    t = pc[31:IDX_W+2];
    return BTB_TAG_W'(t);
  endfunction

  // Instruction PCs are word aligned; the low two bits never index or tag.
  logic [1:0] unused_pc_lsb;
  assign unused_pc_lsb = i_pc_f[1:0] ^ i_upd_pc[1:0];

  // ---------------------------------------------------------------------------
  // IF prediction: old table contents only, no bypass from a same-cycle update.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] f_idx;
  btb_entry_t       f_entry;
  logic             f_hit;

  assign f_idx = i_pc_f[IDX_W+1:2];

  always_comb begin
    f_entry       = btb[f_idx];
    f_hit         = f_entry.valid && (f_entry.tag == pc_tag(i_pc_f));
    o_pred_taken  = f_hit && bht[f_idx][1];
    o_pred_target = o_pred_taken ? f_entry.target : 32'h0;
  end

  // ---------------------------------------------------------------------------
  // EX resolution
  // ---------------------------------------------------------------------------
  logic dec_legal;
  logic dec_taken;
  logic upd_legal;

  br_decide u_decide (
    .funct3 (i_upd_funct3),
    .eq     (i_br_eq),
    .lt     (i_br_lt),
    .legal  (dec_legal),
    .taken  (dec_taken)
  );

  assign upd_legal = i_upd_valid & dec_legal;

  always_comb begin
    // A taken branch whose carried target is wrong is still a mispredict,
    // even if the direction was guessed correctly.
    o_mispredict = upd_legal &
                   ((dec_taken != i_upd_pred_taken) |
                    (dec_taken & (i_upd_pred_target != i_upd_target)));
    if (!o_mispredict)
      o_redirect_pc = 32'h0;
    else if (dec_taken)
      o_redirect_pc = i_upd_target;
    else
      o_redirect_pc = i_upd_pc + 32'd4;
  end

  // ---------------------------------------------------------------------------
  // Table training
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]     u_idx;
  logic [BTB_TAG_W-1:0] u_tag;
  logic                 u_hit;

  always_comb begin
    u_idx = i_upd_pc[IDX_W+1:2];
    u_tag = pc_tag(i_upd_pc);
    u_hit = btb[u_idx].valid && (btb[u_idx].tag == u_tag);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        btb[i] <= '0;
        bht[i] <= WNT;
      end
    end else if (upd_legal) begin
      if (u_hit) begin
        bht[u_idx] <= bht_next(bht[u_idx], dec_taken);
        if (dec_taken)
          btb[u_idx].target <= i_upd_target;
      end else if (dec_taken) begin
        // Miss + taken replaces whatever aliased into this slot.
        btb[u_idx].valid  <= 1'b1;
        btb[u_idx].tag    <= u_tag;
        btb[u_idx].target <= i_upd_target;
        bht[u_idx]        <= WT;
      end
      // Miss + not-taken leaves the tables alone: nothing worth learning.
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_br_cnt  <= 32'h0;
      o_mis_cnt <= 32'h0;
    end else if (upd_legal) begin
      if (o_br_cnt != 32'hFFFF_FFFF)
        o_br_cnt <= o_br_cnt + 32'd1;
      if (o_mispredict && (o_mis_cnt != 32'hFFFF_FFFF))
        o_mis_cnt <= o_mis_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_br_predictor.sv
// Directed bench for br_predictor with a reference table model and an expected-output queue.
// Latency: each step samples combinational outputs 2 time units after the falling edge.
// Backpressure: n/a.
module tb_br_predictor;

  localparam int IDX_W = 6;
  localparam int DEPTH = 1 << IDX_W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [2:0]  upd_funct3;
  logic        br_eq;
  logic        br_lt;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;

  always #5 clk = ~clk;

  br_predictor #(.IDX_W(IDX_W)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_pc_f            (pc_f),
    .o_pred_taken      (pred_taken),
    .o_pred_target     (pred_target),
    .i_upd_valid       (upd_valid),
    .i_upd_pc          (upd_pc),
    .i_upd_funct3      (upd_funct3),
    .i_br_eq           (br_eq),
    .i_br_lt           (br_lt),
    .i_upd_target      (upd_target),
    .i_upd_pred_taken  (upd_pred_taken),
    .i_upd_pred_target (upd_pred_target),
    .o_mispredict      (mispredict),
    .o_redirect_pc     (redirect_pc),
    .o_br_cnt          (br_cnt),
    .o_mis_cnt         (mis_cnt)
  );

  typedef struct {
    string       name;
    logic        pt;
    logic [31:0] ptg;
    logic        mis;
    logic [31:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit          m_valid [DEPTH];
  logic [31:0] m_tag   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_bht   [DEPTH];
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 32'h0;
      m_tgt[i]   = 32'h0;
      m_bht[i]   = 1;
    end
    m_bc = 32'h0;
    m_mc = 32'h0;
  endtask

  function automatic void ref_decide(input logic [2:0] f3, input logic e, input logic l,
                                     output logic legal, output logic tk);
    legal = 1'b1;
    tk    = 1'b0;
    if (f3 == 3'b000)      tk = e;
    else if (f3 == 3'b001) tk = !e;
    else if (f3 == 3'b100 || f3 == 3'b110) tk = l;
    else if (f3 == 3'b101 || f3 == 3'b111) tk = !l;
    else legal = 1'b0;
  endfunction

  // Drive one cycle of stimulus (called just after a falling edge), push the
  // model's expectation, compare it, then advance the model past the next
  // rising edge.
  task automatic step(input string name, input logic [31:0] pcf, input logic v,
                      input logic [31:0] pc, input logic [2:0] f3, input logic e,
                      input logic l, input logic [31:0] tgt, input logic ptk,
                      input logic [31:0] ptg);
    exp_t        x;
    exp_t        got;
    int          fi, ui;
    logic        legal, tk, hit, ul;
    pc_f            = pcf;
    upd_valid       = v;
    upd_pc          = pc;
    upd_funct3      = f3;
    br_eq           = e;
    br_lt           = l;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptg;

    fi  = int'(pcf[IDX_W+1:2]);
    hit = m_valid[fi] && (m_tag[fi] == (pcf >> (IDX_W + 2)));
    ref_decide(f3, e, l, legal, tk);
    ul  = v && legal;
    x.name = name;
    x.pt   = hit && (m_bht[fi] >= 2);
    x.ptg  = x.pt ? m_tgt[fi] : 32'h0;
    x.mis  = ul && ((tk != ptk) || (tk && (ptg != tgt)));
    x.rpc  = !x.mis ? 32'h0 : (tk ? tgt : pc + 32'd4);
    x.bc   = m_bc;
    x.mc   = m_mc;
    sb.push_back(x);

    #2;
    got = sb.pop_front();
    chk({got.name, ".pred_taken"},  {31'h0, pred_taken}, {31'h0, got.pt});
    chk({got.name, ".pred_target"}, pred_target,         got.ptg);
    chk({got.name, ".mispredict"},  {31'h0, mispredict}, {31'h0, got.mis});
    chk({got.name, ".redirect_pc"}, redirect_pc,         got.rpc);
    chk({got.name, ".br_cnt"},      br_cnt,              got.bc);
    chk({got.name, ".mis_cnt"},     mis_cnt,             got.mc);

    if (ul) begin
      ui = int'(pc[IDX_W+1:2]);
      if (m_valid[ui] && (m_tag[ui] == (pc >> (IDX_W + 2)))) begin
        if (tk) begin
          m_bht[ui] = (m_bht[ui] == 3) ? 3 : m_bht[ui] + 1;
          m_tgt[ui] = tgt;
        end else begin
          m_bht[ui] = (m_bht[ui] == 0) ? 0 : m_bht[ui] - 1;
        end
      end else if (tk) begin
        m_valid[ui] = 1'b1;
        m_tag[ui]   = pc >> (IDX_W + 2);
        m_tgt[ui]   = tgt;
        m_bht[ui]   = 2;
      end
      if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
      if (x.mis && (m_mc != 32'hFFFF_FFFF)) m_mc = m_mc + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input string name, input logic [31:0] pcf);
    step(name, pcf, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst_n           = 1'b0;
    pc_f            = 32'h100;
    upd_valid       = 1'b0;
    upd_pc          = 32'h0;
    upd_funct3      = 3'b000;
    br_eq           = 1'b0;
    br_lt           = 1'b0;
    upd_target      = 32'h0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    idle("reset", 32'h100);

    // BEQ taken, first sighting: mispredict to target, allocate WT
    step("beq_alloc", 32'h100, 1'b1, 32'h100, 3'b000, 1'b1, 1'b0, 32'h180, 1'b0, 32'h0);
    idle("beq_pred", 32'h100);

    // Three not-taken resolutions: WT -> WNT -> SNT -> SNT
    step("beq_nt1", 32'h100, 1'b1, 32'h100, 3'b000, 1'b0, 1'b0, 32'h180, 1'b1, 32'h180);
    step("beq_nt2", 32'h100, 1'b1, 32'h100, 3'b000, 1'b0, 1'b0, 32'h180, 1'b0, 32'h0);
    step("beq_nt3", 32'h100, 1'b1, 32'h100, 3'b000, 1'b0, 1'b0, 32'h180, 1'b0, 32'h0);
    idle("beq_snt", 32'h100);

    // BLTU taken at an aliasing PC with same-cycle prediction: old entry seen
    step("bltu_same", 32'h200, 1'b1, 32'h200, 3'b110, 1'b0, 1'b1, 32'h260, 1'b0, 32'h0);
    idle("bltu_next", 32'h200);
    idle("alias_old", 32'h100);

    // Re-allocate 0x100, then replace it again with a taken BNE at 0x200
    step("realloc", 32'h100, 1'b1, 32'h100, 3'b000, 1'b1, 1'b0, 32'h1c0, 1'b0, 32'h0);
    idle("realloc_pred", 32'h100);
    step("bne_alias", 32'h100, 1'b1, 32'h200, 3'b001, 1'b0, 1'b0, 32'h2a0, 1'b0, 32'h0);
    idle("alias_gone", 32'h100);
    idle("alias_new", 32'h200);

    // Illegal funct3: no mispredict, no training, no counting
    step("illegal", 32'h200, 1'b1, 32'h200, 3'b010, 1'b1, 1'b0, 32'h400, 1'b0, 32'h0);
    step("illegal3", 32'h200, 1'b1, 32'h100, 3'b011, 1'b0, 1'b1, 32'h500, 1'b1, 32'h500);
    idle("illegal_after", 32'h200);

    // BGE taken with correct direction but wrong carried target; then saturate up
    step("bge_tgt", 32'h304, 1'b1, 32'h304, 3'b101, 1'b0, 1'b0, 32'h380, 1'b1, 32'h999);
    step("bge_up1", 32'h304, 1'b1, 32'h304, 3'b101, 1'b0, 1'b0, 32'h384, 1'b1, 32'h380);
    step("bge_up2", 32'h304, 1'b1, 32'h304, 3'b101, 1'b0, 1'b0, 32'h384, 1'b1, 32'h384);
    idle("bge_st", 32'h304);

    // BGEU not-taken at the top of memory: redirect wraps to 0
    step("bgeu_wrap", 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 3'b111, 1'b0, 1'b1, 32'h10, 1'b1, 32'h10);
    // BLT not-taken, predicted not-taken: correct, miss leaves table alone
    step("blt_nt", 32'h408, 1'b1, 32'h408, 3'b100, 1'b0, 1'b0, 32'h500, 1'b0, 32'h0);
    idle("blt_noalloc", 32'h408);

    // Reset asserted right after an update edge clears everything at once
    pc_f            = 32'h304;
    upd_valid       = 1'b1;
    upd_pc          = 32'h304;
    upd_funct3      = 3'b000;
    br_eq           = 1'b1;
    br_lt           = 1'b0;
    upd_target      = 32'h3f0;
    upd_pred_taken  = 1'b1;
    upd_pred_target = 32'h384;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("midrst.pred_taken",  {31'h0, pred_taken}, 32'h0);
    chk("midrst.pred_target", pred_target,         32'h0);
    chk("midrst.br_cnt",      br_cnt,              32'h0);
    chk("midrst.mis_cnt",     mis_cnt,             32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_rst", 32'h304);
    idle("post_rst0", 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
